start_rdy_responder: RTL and testbench

START_RDY_RESPONDER -- requirements
Module: start_rdy_responder

---
 rtl/start_rdy_responder.sv | 120 ++++++++++++
 tb/tb_start_rdy_responder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/start_rdy_responder.sv
// start_rdy_responder
//
// Start/ready handshake responder. An initiator pulses START with an operand on
// DIN. The responder then spends BUSY_CYCLES cycles busy with RDY low. It then
// adds the operand into an accumulator, raises DONE for one cycle and returns
// RDY high. A START that arrives while busy is dropped and sets a sticky error
// flag.
//
// Parameters
//   WIDTH        data / accumulator width in bits
//   BUSY_CYCLES  cycles spent busy per job, legal range 1..255
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-low reset
//   START  in   job request pulse, sampled on rising clk
//   DIN    in   job operand, sampled together with an accepted START
//   RDY    out  1 = idle or finished, 0 = job in progress
//   DONE   out  one-cycle completion pulse
//   DOUT   out  running sum of operands modulo 2^WIDTH, valid from DONE onward
//   JOBS   out  completed job count, wraps 255 -> 0
//   ERR    out  sticky: START seen while busy
module start_rdy_responder #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned BUSY_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             START,
  input  logic [WIDTH-1:0] DIN,
  output logic             RDY,
  output logic             DONE,
  output logic [WIDTH-1:0] DOUT,
  output logic [7:0]       JOBS,
  output logic             ERR
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StDone = 2'b10
  } state_e;

  // The counter is loaded with BUSY_CYCLES-1 on accept. BUSY then sees the
  // values N-1 down to 0, which is exactly BUSY_CYCLES cycles.
  localparam logic [7:0] CntLoad = 8'(BUSY_CYCLES - 1);

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [7:0]       jobs_q, jobs_d;
  logic             err_q, err_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= 8'd0;
      operand_q <= '0;
      dout_q    <= '0;
      jobs_q    <= 8'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      operand_q <= operand_d;
      dout_q    <= dout_d;
      jobs_q    <= jobs_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    operand_d = operand_q;
    dout_d    = dout_q;
    jobs_d    = jobs_q;
    err_d     = err_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (START) begin
          operand_d = DIN;
          cnt_d     = CntLoad;
          state_d   = StBusy;
        end else begin
          state_d   = StIdle;
        end
      end

      StBusy: begin
        // A request while busy leaves the operand and counter alone.
        if (START) begin
          err_d = 1'b1;
        end
        if (cnt_q == 8'd0) begin
          state_d = StDone;
          dout_d  = dout_q + operand_q;
          jobs_d  = jobs_q + 8'd1;
        end else begin
          cnt_d   = cnt_q - 8'd1;
        end
      end

      // Unreachable encoding falls back to idle.
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Moore outputs: status decoded from state only, data straight from registers.
  assign RDY  = (state_q == StIdle) || (state_q == StDone);
  assign DONE = (state_q == StDone);
  assign DOUT = dout_q;
  assign JOBS = jobs_q;
  assign ERR  = err_q;

endmodule

// File: tb/tb_start_rdy_responder.sv
// Bench for start_rdy_responder. It runs two instances, one with BUSY_CYCLES=4
// and one with BUSY_CYCLES=1. A job-timeline model predicts every output on
// every cycle. Directed checks with literal values pin the headline scenarios.
module tb_start_rdy_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [7:0] din_a = 8'h00, din_b = 8'h00;
  logic       rdy_a, done_a, err_a, rdy_b, done_b, err_b;
  logic [7:0] dout_a, jobs_a, dout_b, jobs_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  start_rdy_responder #(.WIDTH(8), .BUSY_CYCLES(4)) dut_a (
    .clk(clk), .reset(reset), .START(start_a), .DIN(din_a),
    .RDY(rdy_a), .DONE(done_a), .DOUT(dout_a), .JOBS(jobs_a), .ERR(err_a)
  );

  start_rdy_responder #(.WIDTH(8), .BUSY_CYCLES(1)) dut_b (
    .clk(clk), .reset(reset), .START(start_b), .DIN(din_b),
    .RDY(rdy_b), .DONE(done_b), .DOUT(dout_b), .JOBS(jobs_b), .ERR(err_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ncyc(input int w);
    return (w == 0) ? 4 : 1;
  endfunction

  // Model: each instance remembers the edge at which its current job was accepted.
  // Edges k with acc < k <= acc+N are busy. The job completes at edge acc+N.
  int         k = 0;
  bit         act [2] = '{0, 0};
  int         acc [2] = '{0, 0};
  logic [7:0] m_op [2] = '{8'h00, 8'h00};
  logic [7:0] m_dout [2] = '{8'h00, 8'h00};
  logic [7:0] m_jobs [2] = '{8'h00, 8'h00};
  bit         m_err [2] = '{0, 0};
  bit         m_rdy [2] = '{1, 1};
  bit         m_done [2] = '{0, 0};

  initial begin
    bit         st;
    logic [7:0] d;
    bit         busy;
    int         n;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        k = 0;
        for (int i = 0; i < 2; i++) begin
          act[i] = 0; acc[i] = 0; m_op[i] = 8'h00; m_dout[i] = 8'h00;
          m_jobs[i] = 8'h00; m_err[i] = 0; m_rdy[i] = 1; m_done[i] = 0;
        end
      end else begin
        k++;
        for (int i = 0; i < 2; i++) begin
          st   = (i == 0) ? start_a : start_b;
          d    = (i == 0) ? din_a : din_b;
          n    = ncyc(i);
          busy = act[i] && (k <= acc[i] + n);
          if (act[i] && k == acc[i] + n) begin
            m_dout[i] = m_dout[i] + m_op[i];
            m_jobs[i] = m_jobs[i] + 8'd1;
          end
          if (st) begin
            if (busy) m_err[i] = 1;
            else begin
              act[i] = 1; acc[i] = k; m_op[i] = d;
            end
          end
          m_rdy[i]  = !(act[i] && k < acc[i] + n);
          m_done[i] = act[i] && (k == acc[i] + n);
        end
      end
    end
  end

  // Every-cycle comparison against the model, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      chk($sformatf("a rdy k=%0d", k),  {31'd0, rdy_a},  {31'd0, m_rdy[0]});
      chk($sformatf("a done k=%0d", k), {31'd0, done_a}, {31'd0, m_done[0]});
      chk($sformatf("a dout k=%0d", k), {24'd0, dout_a}, {24'd0, m_dout[0]});
      chk($sformatf("a jobs k=%0d", k), {24'd0, jobs_a}, {24'd0, m_jobs[0]});
      chk($sformatf("a err k=%0d", k),  {31'd0, err_a},  {31'd0, m_err[0]});
      chk($sformatf("b rdy k=%0d", k),  {31'd0, rdy_b},  {31'd0, m_rdy[1]});
      chk($sformatf("b done k=%0d", k), {31'd0, done_b}, {31'd0, m_done[1]});
      chk($sformatf("b dout k=%0d", k), {24'd0, dout_b}, {24'd0, m_dout[1]});
      chk($sformatf("b jobs k=%0d", k), {24'd0, jobs_b}, {24'd0, m_jobs[1]});
      chk($sformatf("b err k=%0d", k),  {31'd0, err_b},  {31'd0, m_err[1]});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int w, input bit s, input logic [7:0] d);
    if (w == 0) begin
      start_a = s; din_a = d;
    end else begin
      start_b = s; din_b = d;
    end
  endtask

  task automatic lit(input int w, input string name, input bit rdy, input bit done,
                     input logic [7:0] dout, input logic [7:0] jobs, input bit err);
    logic       r, dn, e;
    logic [7:0] o, j;
    r  = (w == 0) ? rdy_a : rdy_b;
    dn = (w == 0) ? done_a : done_b;
    o  = (w == 0) ? dout_a : dout_b;
    j  = (w == 0) ? jobs_a : jobs_b;
    e  = (w == 0) ? err_a : err_b;
    chk({name, " rdy"},  {31'd0, r},  {31'd0, rdy});
    chk({name, " done"}, {31'd0, dn}, {31'd0, done});
    chk({name, " dout"}, {24'd0, o},  {24'd0, dout});
    chk({name, " jobs"}, {24'd0, j},  {24'd0, jobs});
    chk({name, " err"},  {31'd0, e},  {31'd0, err});
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b0;
    tick();
    tick();
    lit(0, "reset a", 1, 0, 8'h00, 8'h00, 0);
    lit(1, "reset b", 1, 0, 8'h00, 8'h00, 0);
    reset = 1'b1;
  endtask

  // Jobs of DIN=1 issued back to back, each new START landing in the DONE cycle.
  task automatic back_to_back(input int w, input int count);
    logic [7:0] exp;
    for (int j = 0; j < count; j++) begin
      set_in(w, 1, 8'h01);
      tick();
      set_in(w, 0, 8'h00);
      chk($sformatf("b2b %0d job %0d rdy low", w, j), {31'd0, (w == 0) ? rdy_a : rdy_b}, 32'd0);
      repeat (ncyc(w) - 1) tick();
      tick();
      exp = 8'(j + 1);
      lit(w, $sformatf("b2b %0d job %0d done", w, j), 1, 1, exp, exp, 0);
    end
  endtask

  initial begin
    do_reset();

    // Single job, operand 0x05.
    set_in(0, 1, 8'h05);
    tick();
    set_in(0, 0, 8'h00);
    lit(0, "r26 e0", 0, 0, 8'h00, 8'h00, 0);
    tick(); lit(0, "r26 e1", 0, 0, 8'h00, 8'h00, 0);
    tick(); lit(0, "r26 e2", 0, 0, 8'h00, 8'h00, 0);
    tick(); lit(0, "r26 e3", 0, 0, 8'h00, 8'h00, 0);
    tick(); lit(0, "r26 done", 1, 1, 8'h05, 8'h01, 0);
    tick(); lit(0, "r26 idle", 1, 0, 8'h05, 8'h01, 0);

    // Accumulator wrap: 0xF0 + 0x20 = 0x10.
    do_reset();
    set_in(0, 1, 8'hF0);
    tick();
    set_in(0, 0, 8'h00);
    repeat (4) tick();
    lit(0, "r27 first", 1, 1, 8'hF0, 8'h01, 0);
    tick();
    set_in(0, 1, 8'h20);
    tick();
    set_in(0, 0, 8'h00);
    repeat (4) tick();
    lit(0, "r27 wrap", 1, 1, 8'h10, 8'h02, 0);
    tick();
    lit(0, "r27 idle", 1, 0, 8'h10, 8'h02, 0);

    // START while busy: dropped, ERR set, running job finishes on time.
    set_in(0, 1, 8'h40);
    tick();
    set_in(0, 0, 8'h00);
    tick();
    set_in(0, 1, 8'h77);
    tick();
    set_in(0, 0, 8'h00);
    lit(0, "r28 err", 0, 0, 8'h10, 8'h02, 1);
    tick(); lit(0, "r28 e3", 0, 0, 8'h10, 8'h02, 1);
    tick(); lit(0, "r28 done", 1, 1, 8'h50, 8'h03, 1);

    // START held in the DONE cycle chains straight into a new job.
    set_in(0, 1, 8'h03);
    tick();
    set_in(0, 0, 8'h00);
    lit(0, "r29 chain", 0, 0, 8'h50, 8'h03, 1);
    repeat (3) tick();
    lit(0, "r29 e3", 0, 0, 8'h50, 8'h03, 1);
    tick(); lit(0, "r29 done", 1, 1, 8'h53, 8'h04, 1);
    tick(); lit(0, "r29 idle", 1, 0, 8'h53, 8'h04, 1);

    // Reset in the middle of a job: immediate clear, no DONE afterwards.
    set_in(0, 1, 8'h09);
    tick();
    set_in(0, 0, 8'h00);
    tick();
    #2;
    reset = 1'b0;
    #1;
    lit(0, "r30 async", 1, 0, 8'h00, 8'h00, 0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      lit(0, $sformatf("r30 quiet %0d", i), 1, 0, 8'h00, 8'h00, 0);
    end

    // 256 jobs of +1: JOBS and DOUT both wrap back to zero.
    back_to_back(0, 256);
    lit(0, "r31 a wrapped", 1, 1, 8'h00, 8'h00, 0);
    tick();
    back_to_back(1, 256);
    lit(1, "r31 b wrapped", 1, 1, 8'h00, 8'h00, 0);
    tick();
    lit(1, "r31 b idle", 1, 0, 8'h00, 8'h00, 0);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
